// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - AXI-Lite response codes and bus helpers; AXIL_REG_SLVERR_EN selects the out-of-range response
package axi_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

`ifdef AXIL_REG_SLVERR_EN
  localparam resp_t RESP_RANGE_ERR = RESP_SLVERR;
`else
  localparam resp_t RESP_RANGE_ERR = RESP_OKAY;
`endif

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/axi_lite_reg_slave_if.sv
// rtl/axi_lite_reg_slave_if.sv - AXI4-Lite bus bundle with master/slave views
interface axi_lite_reg_slave_if
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0]                 AWADDR;
  logic [2:0]                            AWPROT;
  logic                                  AWVALID;
  logic                                  AWREADY;
  logic [DATA_WIDTH-1:0]                 WDATA;
  logic [strb_width(DATA_WIDTH)-1:0]     WSTRB;
  logic                                  WVALID;
  logic                                  WREADY;
  logic [1:0]                            BRESP;
  logic                                  BVALID;
  logic                                  BREADY;
  logic [ADDR_WIDTH-1:0]                 ARADDR;
  logic                                  ARVALID;
  logic                                  ARREADY;
  logic [DATA_WIDTH-1:0]                 RDATA;
  logic [1:0]                            RRESP;
  logic                                  RVALID;
  logic                                  RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

endinterface

// File: rtl/axil_reg_wr_chan.sv
// rtl/axil_reg_wr_chan.sv - AW/W holding slots, commit strobe and B response register
module axil_reg_wr_chan
  import axi_lite_pkg::*;
#(
  parameter int  ADDR_WIDTH = 32,
  parameter int  DATA_WIDTH = 32,
  localparam int STRB_W     = strb_width(DATA_WIDTH)
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  init_done,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_W-1:0]     wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic                  bvalid,
  output resp_t                 bresp,
  input  logic                  bready,
  input  logic                  addr_ok,
  output logic                  commit,
  output logic [ADDR_WIDTH-1:0] commit_addr,
  output logic [DATA_WIDTH-1:0] commit_data,
  output logic [STRB_W-1:0]     commit_strb
);

  logic aw_full;
  logic w_full;

  assign awready = init_done & ~aw_full & ~bvalid;
  assign wready  = init_done & ~w_full & ~bvalid;
  // Both slots are filled only while no response is pending, so a commit never meets a live BVALID.
  assign commit  = aw_full & w_full;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_full     <= 1'b0;
      w_full      <= 1'b0;
      commit_addr <= '0;
      commit_data <= '0;
      commit_strb <= '0;
      bvalid      <= 1'b0;
      bresp       <= RESP_OKAY;
    end else if (commit) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      bvalid  <= 1'b1;
      bresp   <= addr_ok ? RESP_OKAY : RESP_RANGE_ERR;
    end else begin
      if (awvalid && awready) begin
        aw_full     <= 1'b1;
        commit_addr <= awaddr;
      end
      if (wvalid && wready) begin
        w_full      <= 1'b1;
        commit_data <= wdata;
        commit_strb <= wstrb;
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi_lite_reg_slave.sv
// rtl/axi_lite_reg_slave.sv - AXI4-Lite register bank slave; define AXIL_REG_SLVERR_EN for SLVERR on out-of-range
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  axi_lite_reg_slave_if.slave            bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int STRB_W = strb_width(DATA_WIDTH);
  localparam int OFS_W  = $clog2(STRB_W);
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  // One bit wider than the bus so a span reaching the top of the address space still compares correctly.
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(NUM_REGS * STRB_W);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return {1'b0, addr} < SPAN;
  endfunction

  function automatic logic [IDX_W-1:0] reg_index(input logic [ADDR_WIDTH-1:0] addr);
    return IDX_W'(addr >> OFS_W);
  endfunction

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  logic                                init_done;
  logic                                commit;
  logic [ADDR_WIDTH-1:0]               c_addr;
  logic [DATA_WIDTH-1:0]               c_data;
  logic [STRB_W-1:0]                   c_strb;
  logic                                wr_ok;
  logic [IDX_W-1:0]                    widx;
  resp_t                               b_resp;
  logic                                unused_prot;

  assign regs_o      = regs;
  assign wr_ok       = in_range(c_addr);
  assign widx        = reg_index(c_addr);
  assign bus.BRESP   = b_resp;
  assign bus.ARREADY = init_done & ~bus.RVALID;
  assign unused_prot = ^bus.AWPROT;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) init_done <= 1'b0;
    else          init_done <= 1'b1;
  end

  axil_reg_wr_chan #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wr_chan (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .init_done   (init_done),
    .awaddr      (bus.AWADDR),
    .awvalid     (bus.AWVALID),
    .awready     (bus.AWREADY),
    .wdata       (bus.WDATA),
    .wstrb       (bus.WSTRB),
    .wvalid      (bus.WVALID),
    .wready      (bus.WREADY),
    .bvalid      (bus.BVALID),
    .bresp       (b_resp),
    .bready      (bus.BREADY),
    .addr_ok     (wr_ok),
    .commit      (commit),
    .commit_addr (c_addr),
    .commit_data (c_data),
    .commit_strb (c_strb)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      regs       <= '0;
      wr_pulse_o <= '0;
    end else begin
      wr_pulse_o <= '0;
      if (commit && wr_ok) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (c_strb[b]) regs[widx][8*b +: 8] <= c_data[8*b +: 8];
        end
        wr_pulse_o[widx] <= 1'b1;
      end
    end
  end

  // Captures pre-commit contents when a read and a write commit share an edge.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      bus.RVALID <= 1'b0;
      bus.RDATA  <= '0;
      bus.RRESP  <= RESP_OKAY;
    end else if (bus.ARVALID && bus.ARREADY) begin
      bus.RVALID <= 1'b1;
      if (in_range(bus.ARADDR)) begin
        bus.RDATA <= regs[reg_index(bus.ARADDR)];
        bus.RRESP <= RESP_OKAY;
      end else begin
        bus.RDATA <= '0;
        bus.RRESP <= RESP_RANGE_ERR;
      end
    end else if (bus.RVALID && bus.RREADY) begin
      bus.RVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// tb/tb_axi_lite_reg_slave.sv - self-checking bench for axi_lite_reg_slave with a register-bank reference model
module tb_axi_lite_reg_slave;

`ifdef AXIL_REG_SLVERR_EN
  localparam logic [1:0] EXP_ERR = 2'b10;
`else
  localparam logic [1:0] EXP_ERR = 2'b00;
`endif

  logic         ACLK;
  logic         ARESETn;
  logic [255:0] regs_o;
  logic [7:0]   wr_pulse_o;
  logic [31:0]  model [8];
  int           checks = 0;
  int           errors = 0;

  axi_lite_reg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_lite_reg_slave #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .NUM_REGS   (8)
  ) dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .bus        (bus),
    .regs_o     (regs_o),
    .wr_pulse_o (wr_pulse_o)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_reg%0d", tag, i), 64'(regs_o[i*32 +: 32]), 64'(model[i]));
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (addr < 32) begin
      for (int b = 0; b < 4; b++) if (strb[b]) model[addr[4:2]][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic apply_reset();
    ARESETn = 1'b0;
    bus.AWVALID = 0; bus.WVALID = 0; bus.ARVALID = 0; bus.BREADY = 0; bus.RREADY = 0;
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    #1;
    chk("rst_async_regs", 64'(regs_o), 64'h0);
    chk("rst_async_bvalid", 64'(bus.BVALID), 64'h0);
    repeat (2) @(posedge ACLK);
    #3;
    ARESETn = 1'b1;
    chk("rel_awready", 64'(bus.AWREADY), 64'h0);
    chk("rel_wready", 64'(bus.WREADY), 64'h0);
    chk("rel_arready", 64'(bus.ARREADY), 64'h0);
    chk("rel_rvalid", 64'(bus.RVALID), 64'h0);
    chk("rel_pulse", 64'(wr_pulse_o), 64'h0);
    chk_regs("rel");
    @(posedge ACLK); #1;
    chk("init_ready", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'h7);
  endtask

  task automatic send_aw(input logic [31:0] addr, input int dly);
    int   n;
    logic rdy;
    repeat (dly) begin @(posedge ACLK); #1; end
    bus.AWADDR = addr; bus.AWPROT = 3'($urandom); bus.AWVALID = 1'b1; n = 0;
    do begin rdy = bus.AWREADY; @(posedge ACLK); #1; n++; end while (!rdy && n < 50);
    bus.AWVALID = 1'b0;
    chk("aw_handshake", 64'(rdy), 64'h1);
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
    int   n;
    logic rdy;
    repeat (dly) begin @(posedge ACLK); #1; end
    bus.WDATA = data; bus.WSTRB = strb; bus.WVALID = 1'b1; n = 0;
    do begin rdy = bus.WREADY; @(posedge ACLK); #1; n++; end while (!rdy && n < 50);
    bus.WVALID = 1'b0;
    chk("w_handshake", 64'(rdy), 64'h1);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_hold);
    logic [7:0] exp_pulse;
    logic [1:0] exp_resp;
    exp_pulse = (addr < 32) ? (8'h01 << addr[4:2]) : 8'h00;
    exp_resp  = (addr < 32) ? 2'b00 : EXP_ERR;
    fork
      send_aw(addr, aw_dly);
      send_w(data, strb, w_dly);
    join
    chk("b_not_early", 64'(bus.BVALID), 64'h0);
    model_write(addr, data, strb);
    @(posedge ACLK); #1;
    chk("bvalid", 64'(bus.BVALID), 64'h1);
    chk("bresp", 64'(bus.BRESP), 64'(exp_resp));
    chk("wr_pulse", 64'(wr_pulse_o), 64'(exp_pulse));
    chk("ready_blocked", 64'({bus.AWREADY, bus.WREADY}), 64'h0);
    chk_regs("wr");
    repeat (b_hold) begin
      @(posedge ACLK); #1;
      chk("bvalid_hold", 64'(bus.BVALID), 64'h1);
      chk("bresp_hold", 64'(bus.BRESP), 64'(exp_resp));
      chk("pulse_once", 64'(wr_pulse_o), 64'h0);
    end
    bus.BREADY = 1'b1;
    @(posedge ACLK); #1;
    bus.BREADY = 1'b0;
    chk("bvalid_clear", 64'(bus.BVALID), 64'h0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int r_hold);
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    int          n;
    logic        rdy;
    exp_data = (addr < 32) ? model[addr[4:2]] : 32'h0;
    exp_resp = (addr < 32) ? 2'b00 : EXP_ERR;
    bus.ARADDR = addr; bus.ARVALID = 1'b1; n = 0;
    do begin rdy = bus.ARREADY; @(posedge ACLK); #1; n++; end while (!rdy && n < 50);
    bus.ARVALID = 1'b0;
    chk("ar_handshake", 64'(rdy), 64'h1);
    chk("rvalid", 64'(bus.RVALID), 64'h1);
    chk("rdata", 64'(bus.RDATA), 64'(exp_data));
    chk("rresp", 64'(bus.RRESP), 64'(exp_resp));
    chk("arready_busy", 64'(bus.ARREADY), 64'h0);
    repeat (r_hold) begin
      @(posedge ACLK); #1;
      chk("rvalid_hold", 64'(bus.RVALID), 64'h1);
      chk("rdata_hold", 64'(bus.RDATA), 64'(exp_data));
    end
    bus.RREADY = 1'b1;
    @(posedge ACLK); #1;
    bus.RREADY = 1'b0;
    chk("rvalid_clear", 64'(bus.RVALID), 64'h0);
  endtask

  initial begin
    logic [31:0] addr;
    logic [31:0] data;
    bus.AWADDR = '0; bus.AWPROT = '0; bus.WDATA = '0; bus.WSTRB = '0; bus.ARADDR = '0;
    apply_reset();

    axi_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 3);
    chk("reg1_value", 64'(regs_o[63:32]), 64'hDEADBEEF);

    axi_write(32'h8, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    axi_write(32'h8, 32'h11223344, 4'b0101, 2, 0, 1);
    chk("reg2_merge", 64'(regs_o[95:64]), 64'hAA22CC44);

    axi_read(32'h4, 2);
    axi_read(32'h9, 0);

    axi_write(32'h40, 32'hCAFEF00D, 4'hF, 0, 0, 1);
    axi_read(32'h40, 1);

    axi_write(32'hC, 32'hFFFFFFFF, 4'h0, 1, 0, 0);
    chk("strb0_reg3", 64'(regs_o[127:96]), 64'h0);

    for (int it = 0; it < 60; it++) begin
      addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 39));
      data = $urandom;
      if ($urandom_range(0, 1) == 0)
        axi_write(addr, data, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        axi_read(addr, $urandom_range(0, 2));
    end

    send_aw(32'h8, 0);
    apply_reset();
    chk("mid_rst_bvalid", 64'(bus.BVALID), 64'h0);
    send_w(32'h5A5A5A5A, 4'hF, 0);
    repeat (3) begin
      @(posedge ACLK); #1;
      chk("orphan_w_no_b", 64'(bus.BVALID), 64'h0);
      chk("orphan_w_no_pulse", 64'(wr_pulse_o), 64'h0);
    end
    chk_regs("orphan");
    send_aw(32'h0, 0);
    model_write(32'h0, 32'h5A5A5A5A, 4'hF);
    @(posedge ACLK); #1;
    chk("late_aw_bvalid", 64'(bus.BVALID), 64'h1);
    chk("late_aw_pulse", 64'(wr_pulse_o), 64'h01);
    chk_regs("late_aw");
    bus.BREADY = 1'b1;
    @(posedge ACLK); #1;
    bus.BREADY = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_slave.md
# axi_lite_reg_slave

AXI4-Lite responder that terminates the AXI-Lite interface's slave side and exposes a bank of NUM_REGS read/write control registers to surrounding logic. It sits behind the SoC interconnect or CPU data port and gives peripherals a memory-mapped control/status block. Write address and write data may arrive in any order, and each transaction gets a registered response.

## Interface
- DATA_WIDTH, 32, data bus width in bits; a multiple of 8.
- ADDR_WIDTH, 32, address bus width in bits.
- NUM_REGS, 8, number of registers; at least 1.
- ACLK  input  1  clock; all logic on rising edge.
- ARESETn  input  1  reset; one clock, reset is asynchronous and active-low.
- AWADDR/AWVALID/AWPROT  input  ADDR_WIDTH/1/3  write address channel; AWPROT is ignored.
- AWREADY  output  1  write address ready.
- WDATA/WSTRB/WVALID  input  DATA_WIDTH/DATA_WIDTH/8/1  write data channel.
- WREADY  output  1  write data ready.
- BRESP/BVALID  output  2/1  write response.
- BREADY  input  1  write response ready.
- ARADDR/ARVALID  input  ADDR_WIDTH/1  read address channel.
- ARREADY  output  1  read address ready.
- RDATA/RRESP/RVALID  output  DATA_WIDTH/2/1  read data channel.
- RREADY  input  1  read data ready.
- regs_o  output  NUM_REGS*DATA_WIDTH  register contents; register i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- wr_pulse_o  output  NUM_REGS  one-cycle strobe on commit to register i.

## Operation
- Decode: byte offset = addr mod (DATA_WIDTH/8) and is ignored. Index = addr / (DATA_WIDTH/8). An address is in range iff addr < NUM_REGS*DATA_WIDTH/8.
- Write channel uses two holding slots, aw_full and w_full, filled independently.
  - AWREADY = init_done & ~aw_full & ~BVALID.
  - WREADY = init_done & ~w_full & ~BVALID.
- When both slots are full, the commit happens on the next edge:
  - in-range: register byte lanes with WSTRB=1 take WDATA, other lanes keep their value, and wr_pulse_o[idx] is high for that one cycle.
  - out-of-range: nothing is written and no pulse is issued.
  - In both cases the slots are cleared and BVALID is set with BRESP.
- BVALID holds, with BRESP stable, until BREADY is sampled high. New AW/W are not accepted while BVALID=1.
- A write with WSTRB=0 counts as a legal commit: no bytes change, the pulse still fires, and BRESP=OKAY.
- Read channel: ARREADY = init_done & ~RVALID.
  - On the AR handshake, RDATA is captured from the current register contents (in-range) or set to 0 (out-of-range), and RVALID is set.
  - RVALID/RDATA/RRESP hold until RREADY is sampled high.
- Read and write channels are independent.
  - A read captured on the same edge a write commits returns the old value.
  - A read handshaking after the commit edge returns the new value.
- Reset is asynchronous:
  - all registers go to 0, slots are cleared, and BVALID, RVALID, wr_pulse_o, RDATA, BRESP and RRESP go to 0.
  - init_done resets to 0 and sets on the first edge after release, so all READY outputs are 0 during reset and in the first cycle after release.
  - Reset mid-transaction abandons the transaction with no write and no response.

## Timing
- AW and W handshake on the same edge N → commit, BVALID=1 and the updated regs_o all take effect after edge N+1.
- AW at edge N, W at edge M>N → commit and BVALID take effect after edge M+1.
- Minimum write throughput: one write per 3 cycles (accept, commit, B handshake).
- AR handshake at edge N → RVALID=1 after edge N, with 1-cycle latency. With RREADY held high, one read every 2 cycles.

## Configuration
- AXIL_REG_SLVERR_EN defined: out-of-range writes and reads respond SLVERR (2'b10).
- Not defined: out-of-range accesses respond OKAY (2'b00).
- Data behaviour is the same either way: writes are dropped and reads return 0.

## Structure
- Package axi_lite_pkg holds:
  - the response type with RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - a helper function for the strobe width, DATA_WIDTH/8.
- One sub-module: axil_reg_wr_chan, holding the AW/W slots, the B response register and the commit strobe.
- The read path, register array and decode stay in the top module.

## Test plan
- Reset release: all READY outputs are 0 in the first cycle after release and 1 in the second; regs_o=0.
- AW and W for address 0x4 with WDATA=0xDEADBEEF and WSTRB=4'hF presented together:
  - after one cycle, regs_o reg1=0xDEADBEEF, wr_pulse_o=8'h02 for one cycle, BVALID=1 and BRESP=OKAY;
  - BREADY held low for 3 cycles keeps BVALID=1.
- W with WDATA=0x11223344 and WSTRB=4'b0101 arrives 2 cycles before AW at address 0x8, with reg2 previously 0xAABBCCDD: the result is reg2=0xAA22CC44.
- Read from address 0x4 with RREADY low for 2 cycles: RDATA=0xDEADBEEF is held stable and RRESP=OKAY.
- Write and read to address 0x40 (out of range, NUM_REGS=8): no pulse, RDATA=0, and the response is SLVERR with the macro defined, OKAY without it.
- ARESETn asserted after the AW handshake but before W: no write happens, BVALID stays 0, and regs_o=0.
